// File: rtl/subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding, default width
// and the bit-counter width helper.
package subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // The counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
    function automatic int cnt_width(input int width);
        return ($clog2(width) < 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_subtractor_mux.sv
// Combinational full subtractor (x - y - bin) built purely from 2:1 muxes.
module full_subtractor_mux (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic y_n;
    logic xy_xor;
    logic xy_xnor;
    logic y_or_bin;
    logic y_and_bin;

    // Inversion comes from a mux choosing between constants.
    mux2_1 u_inv_y   (.sel(y),      .d0(1'b1),   .d1(1'b0),    .y(y_n));
    mux2_1 u_xor_xy  (.sel(x),      .d0(y),      .d1(y_n),     .y(xy_xor));
    mux2_1 u_inv_xor (.sel(xy_xor), .d0(1'b1),   .d1(1'b0),    .y(xy_xnor));
    mux2_1 u_diff    (.sel(bin),    .d0(xy_xor), .d1(xy_xnor), .y(d));

    // With x=0 a borrow occurs if y|bin; with x=1 only if y&bin.
    mux2_1 u_or      (.sel(y),      .d0(bin),    .d1(1'b1),    .y(y_or_bin));
    mux2_1 u_and     (.sel(y),      .d0(1'b0),   .d1(bin),     .y(y_and_bin));
    mux2_1 u_borrow  (.sel(x),      .d0(y_or_bin), .d1(y_and_bin), .y(bout));

endmodule

// File: rtl/mux2_1.sv
// 2:1 multiplexer, the only primitive used to build the subtractor cell.
module mux2_1 (
    input  logic sel,
    input  logic d0,
    input  logic d1,
    output logic y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/serial_subtractor_mux.sv
// Bit-serial a - b, LSB first, one bit per clock behind a start/done handshake.
module serial_subtractor_mux
    import subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             d;
    logic             bout;

    full_subtractor_mux u_cell (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .bin  (borrow),
        .d    (d),
        .bout (bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            borrow     <= 1'b0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        borrow <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= {d, res_sr[WIDTH-1:1]};
                    borrow <= bout;
                    // The last bit-step writes the result straight into the output registers.
                    if (cnt == LAST) begin
                        diff       <= {d, res_sr[WIDTH-1:1]};
                        borrow_out <= bout;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_mux.sv
// Scoreboard bench for serial_subtractor_mux plus an exhaustive check of the mux-based cell.
module tb_serial_subtractor_mux;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;

    logic cx, cy, cb, cd, cbo;

    typedef struct {
        logic [W-1:0] diff;
        logic         borrow;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   compared   = 0;
    int   mismatched = 0;
    int   busy_run   = 0;

    serial_subtractor_mux #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    full_subtractor_mux u_cell (
        .x    (cx),
        .y    (cy),
        .bin  (cb),
        .d    (cd),
        .bout (cbo)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the oldest expected result whenever done is presented.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                if (sb_q.size() == 0) begin
                    check_output("unexpected_done", 1, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check_output("diff", diff, mon_e.diff);
                    check_output("borrow_out", borrow_out, mon_e.borrow);
                    check_output("busy_cycles", busy_run, W);
                end
                busy_run = 0;
            end
        end
    end

    // Leaves the bench at the negedge just after the accepting edge; operands then get scrambled.
    task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        e.diff   = W'((int'(av) - int'(bv)) & ((1 << W) - 1));
        e.borrow = (int'(av) < int'(bv));
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
    endtask

    // n is the index of the current negedge counted from the accepting edge.
    task automatic wait_done(input int n_start);
        int n = n_start;
        while (n <= W + 3 && !done) begin
            @(negedge clk);
            n++;
        end
        if (!done) check_output("done_timeout", 0, 1);
        else       check_output("done_latency", n, W + 1);
    endtask

    task automatic apply_stimulus(input logic [W-1:0] av, input logic [W-1:0] bv);
        accept(av, bv);
        wait_done(1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;

        for (int i = 0; i < 8; i++) begin
            {cx, cy, cb} = 3'(i);
            #1;
            r = int'(cx) - int'(cy) - int'(cb);
            check_output("cell_d", cd, r & 1);
            check_output("cell_bout", cbo, r < 0);
        end

        #2;
        check_output("reset_busy", busy, 0);
        check_output("reset_done", done, 0);
        check_output("reset_diff", diff, 0);
        check_output("reset_borrow", borrow_out, 0);
        @(negedge clk);
        rst_n = 1'b1;

        apply_stimulus(8'h5A, 8'h3C);
        apply_stimulus(8'h00, 8'h01);
        apply_stimulus(8'hA5, 8'hA5);
        apply_stimulus(8'hFF, 8'h00);

        // Requests during SHIFT cycle 3 and during DONE must be dropped.
        accept(8'h33, 8'h11);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        a     = 8'h10;
        b     = 8'h01;
        @(negedge clk);
        start = 1'b0;
        wait_done(4);
        start = 1'b1;
        a     = 8'h10;
        b     = 8'h01;
        @(negedge clk);
        start = 1'b0;
        check_output("idle_busy_0", busy, 0);
        @(negedge clk);
        check_output("idle_busy_1", busy, 0);
        check_output("idle_done_1", done, 0);
        apply_stimulus(8'h10, 8'h01);

        for (int i = 0; i < 20; i++) begin
            apply_stimulus(W'($urandom), W'($urandom));
        end

        // Abort mid-operation right after a result with a borrow was latched.
        apply_stimulus(8'h00, 8'h01);
        accept(8'hC3, 8'h42);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_output("abort_busy", busy, 0);
        check_output("abort_done", done, 0);
        check_output("abort_diff", diff, 0);
        check_output("abort_borrow", borrow_out, 0);
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(8'h80, 8'h7F);

        @(negedge clk);
        @(negedge clk);
        check_output("queue_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/serial_subtractor_mux.md
# serial_subtractor_mux

Bit-serial WIDTH-bit subtractor computing diff = a − b, LSB first, one bit per clock. Each bit goes through a full-subtractor cell built only from 2:1 muxes, and the borrow is held in a flip-flop between bits. It is the inverse-operation companion to the mux-based full adder. It serves as a low-area arithmetic unit for control datapaths, behind a start/done handshake.

## Interface
- WIDTH, 8, operand and result width in bits (≥ 2).

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; sampled on the accepting edge only.
- b  input  WIDTH  subtrahend; sampled on the accepting edge only.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse; diff and borrow_out are valid from this cycle on.
- diff  output  WIDTH  registered result a − b mod 2^WIDTH.
- borrow_out  output  1  registered final borrow; 1 iff a < b as unsigned.

## Operation
- Reset: state=IDLE, busy=0, done=0, diff=0, borrow_out=0, internal shift registers, borrow flop and bit counter all 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE → SHIFT on start=1. On that edge: load a_sr←a, b_sr←b, borrow←0, cnt←0.
- SHIFT, every edge:
  - Cell inputs are x=a_sr[0], y=b_sr[0], bin=borrow.
  - d = x^y^bin.
  - bout = (~x&y) | (~x&bin) | (y&bin).
  - a_sr and b_sr shift right by one.
  - res_sr ← {d, res_sr[WIDTH-1:1]}.
  - borrow←bout, cnt←cnt+1.
- SHIFT → DONE on the edge where cnt==WIDTH−1, i.e. after WIDTH bit-steps. On that edge, diff←final res_sr value including the last d, and borrow_out←last bout.
- DONE → IDLE unconditionally on the next edge.
- done=1 only in DONE.
- diff and borrow_out hold their values until the next completion or reset. They never change in IDLE or SHIFT.
- start is ignored in SHIFT and DONE. There is no queuing. Changes on a and b after acceptance have no effect.
- Counter width is $clog2(WIDTH). It never wraps within an operation.
- Reset asserted mid-operation aborts immediately. All outputs and state return to their reset values, and no done is produced.

## Timing
- Accepting edge is E0 (start=1 in IDLE).
- busy=1 for cycles E0..E0+WIDTH, i.e. WIDTH cycles.
- done=1 for exactly the cycle between E0+WIDTH and E0+WIDTH+1.
- Latency is WIDTH+1 edges from the accepting edge to the edge after which done deasserts.
- Throughput is one operation per WIDTH+2 cycles. The earliest new accept is the edge ending the first IDLE cycle after DONE.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Structure
- Shared package subtractor_pkg holds:
  - state encoding localparams (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - default WIDTH constant;
  - counter-width function.
- Sub-module full_subtractor_mux is a purely combinational cell (x, y, bin → d, bout). It is built only from mux2_1 instances and instantiated once in the datapath.
- The top module holds the FSM, counter, shift registers, borrow flop and output registers.

## Test plan
- Basic subtraction: WIDTH=8, a=0x5A, b=0x3C, start pulse → done after 9 edges, diff=0x1E, borrow_out=0, busy high for exactly 8 cycles.
- Underflow: a=0x00, b=0x01 → diff=0xFF, borrow_out=1.
- Equal operands: a=0xA5, b=0xA5 → diff=0x00, borrow_out=0. Follow with a=0xFF, b=0x00 → diff=0xFF, borrow_out=0.
- Ignored requests: assert start with new operands (a=0x10, b=0x01) in SHIFT cycle 3 and again in the DONE cycle → the first result is unaffected, and no second operation starts until start is reasserted in IDLE. That later start gives diff=0x0F.
- Reset mid-operation: assert rst_n=0 during SHIFT cycle 4 → busy, done, diff and borrow_out go to 0 immediately. After release, start with a=0x80, b=0x7F gives diff=0x01, borrow_out=0.
- Exhaustive cell check: drive full_subtractor_mux with all 8 input combinations → d and bout match the equations in Operation.
